// File: rtl/pid_pkg.sv
// Shared types and helpers for the multi-channel PID controller (pid_mc).
// Holds the FSM state encoding, width helpers and the saturation functions
// used by both the datapath and the accumulator stage.
package pid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_MUL_P,
    ST_MUL_I,
    ST_MUL_D,
    ST_SUM,
    ST_DONE
  } pid_state_t;

  // Accumulator width: gain (zero-extended) times operand, plus headroom for three terms.
  function automatic int acc_w(input int coef_w, input int op_w);
    return coef_w + op_w + 3;
  endfunction

  // Channel index width; a single channel still gets a one-bit select.
  function automatic int ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic longint sat_signed(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Clamp a signed value into [0, 2^w - 1].
  function automatic longint sat_unsigned(input longint v, input int w);
    longint hi;
    hi = (longint'(1) <<< w) - 1;
    if (v > hi) return hi;
    if (v < 0) return 0;
    return v;
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Registered signed multiply-accumulate; the only multiplier in the PID.
// clr restarts the sum (loading the product when en is also high),
// en adds the current product to the running sum.
module pid_mac #(
  parameter int A_W   = 17,
  parameter int B_W   = 20,
  parameter int ACC_W = 39
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] prod;

  assign prod = P_W'(a) * P_W'(b);

  // Accumulator register: clear, load or add the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= en ? ACC_W'(prod) : '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/pid_mc.sv
// Time-multiplexed multi-channel PID controller with one shared multiplier,
// per-channel integrator / previous-error state, output saturation and
// conditional-integration anti-windup.
// Optional derivative term: define PID_DERIV_EN to add the MUL_D step and
// the per-channel previous-error storage; without it kd is ignored.
module pid_mc
  import pid_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 8,
  parameter int CH     = 4,
  parameter int INT_W  = DATA_W + 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pid_start,
  input  logic [ch_w(CH)-1:0]   ch_sel,
  input  logic [DATA_W-1:0]     setpoint,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [COEF_W-1:0]     kp,
  input  logic [COEF_W-1:0]     ki,
  input  logic [COEF_W-1:0]     kd,
  output logic                  busy,
  output logic                  done,
  output logic [ch_w(CH)-1:0]   ch_out,
  output logic [DATA_W-1:0]     data_out
);

  localparam int CH_W  = ch_w(CH);
  localparam int E_W   = DATA_W + 1;
  localparam int D_W   = DATA_W + 2;
  // Multiplier operand must hold the integrator and the error difference.
  localparam int OP_W  = (INT_W > D_W) ? INT_W : D_W;
  localparam int GA_W  = COEF_W + 1;
  localparam int ACC_W = acc_w(COEF_W, OP_W);

  pid_state_t state;

  logic [CH_W-1:0]          ch_q;
  logic [DATA_W-1:0]        sp_q;
  logic [DATA_W-1:0]        din_q;
  logic [COEF_W-1:0]        kp_q;
  logic [COEF_W-1:0]        ki_q;
  logic signed [E_W-1:0]    e_q;
  logic signed [E_W-1:0]    e_c;
  logic signed [INT_W-1:0]  i_new_q;
  logic signed [INT_W-1:0]  i_new_c;
  logic signed [INT_W-1:0]  integ [CH];
  logic                     sat_hi_q;
  logic                     sat_lo_q;
  logic                     freeze;

  logic                     mac_clr;
  logic                     mac_en;
  logic signed [GA_W-1:0]   mac_a;
  logic signed [OP_W-1:0]   mac_b;
  logic signed [ACC_W-1:0]  acc;

  longint                   u_full;
  longint                   u_sat;

`ifdef PID_DERIV_EN
  logic [COEF_W-1:0]        kd_q;
  logic signed [D_W-1:0]    d_q;
  logic signed [D_W-1:0]    d_c;
  logic signed [E_W-1:0]    e_prev [CH];
`else
  logic                     unused_kd;
  assign unused_kd = ^kd;
`endif

  // Error, derivative and saturated integrator candidate for the latched channel.
  always_comb begin
    e_c     = $signed({1'b0, sp_q}) - $signed({1'b0, din_q});
    i_new_c = INT_W'(sat_signed(longint'(integ[ch_q]) + longint'(e_c), INT_W));
`ifdef PID_DERIV_EN
    d_c     = D_W'(e_c) - D_W'(e_prev[ch_q]);
`endif
  end

  // Scale the accumulated sum back to integer units and clamp to the output range.
  always_comb begin
    u_full = longint'(acc) >>> FRAC_W;
    u_sat  = sat_unsigned(u_full, DATA_W);
  end

  // Hold the integrator when it would push further into the saturated direction.
  assign freeze = (sat_hi_q && !e_q[E_W-1]) || (sat_lo_q && e_q[E_W-1]);

  // Route one gain/operand pair per multiply state into the shared MAC.
  always_comb begin
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    case (state)
      ST_MUL_P: begin
        mac_clr = 1'b1;
        mac_en  = 1'b1;
        mac_a   = $signed({1'b0, kp_q});
        mac_b   = OP_W'(e_q);
      end
      ST_MUL_I: begin
        mac_en  = 1'b1;
        mac_a   = $signed({1'b0, ki_q});
        mac_b   = OP_W'(i_new_q);
      end
`ifdef PID_DERIV_EN
      ST_MUL_D: begin
        mac_en  = 1'b1;
        mac_a   = $signed({1'b0, kd_q});
        mac_b   = OP_W'(d_q);
      end
`endif
      default: begin
        mac_en  = 1'b0;
      end
    endcase
  end

  pid_mac #(
    .A_W   (GA_W),
    .B_W   (OP_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (mac_a),
    .b   (mac_b),
    .acc (acc)
  );

  // Sequencer: latches a request, steps through the multiply states, publishes
  // the result and commits the channel state only after the result is out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ch_out   <= '0;
      data_out <= '0;
      ch_q     <= '0;
      sp_q     <= '0;
      din_q    <= '0;
      kp_q     <= '0;
      ki_q     <= '0;
      e_q      <= '0;
      i_new_q  <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
      for (int i = 0; i < CH; i++) integ[i] <= '0;
`ifdef PID_DERIV_EN
      kd_q     <= '0;
      d_q      <= '0;
      for (int i = 0; i < CH; i++) e_prev[i] <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pid_start) begin
            if (int'(ch_sel) >= CH) ch_q <= CH_W'(CH - 1);
            else                    ch_q <= ch_sel;
            sp_q  <= setpoint;
            din_q <= data_in;
            kp_q  <= kp;
            ki_q  <= ki;
`ifdef PID_DERIV_EN
            kd_q  <= kd;
`endif
            busy  <= 1'b1;
            state <= ST_ERR;
          end
        end
        ST_ERR: begin
          e_q     <= e_c;
          i_new_q <= i_new_c;
`ifdef PID_DERIV_EN
          d_q     <= d_c;
`endif
          state   <= ST_MUL_P;
        end
        ST_MUL_P: begin
          state <= ST_MUL_I;
        end
        ST_MUL_I: begin
`ifdef PID_DERIV_EN
          state <= ST_MUL_D;
`else
          state <= ST_SUM;
`endif
        end
`ifdef PID_DERIV_EN
        ST_MUL_D: begin
          state <= ST_SUM;
        end
`endif
        ST_SUM: begin
          data_out <= DATA_W'(u_sat);
          ch_out   <= ch_q;
          sat_hi_q <= (u_full > u_sat);
          sat_lo_q <= (u_full < 0);
          done     <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: begin
`ifdef PID_DERIV_EN
          e_prev[ch_q] <= e_q;
`endif
          if (!freeze) integ[ch_q] <= i_new_q;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pid_mc.sv
// Directed, table-driven bench for pid_mc with default parameters
// (16-bit data, Q8.8 gains, 4 channels). Expected outputs are hand-computed;
// PID_DERIV_EN selects the latency and the derivative-vector results.
module tb_pid_mc;

`ifdef PID_DERIV_EN
  localparam int LAT   = 6;
  localparam bit DERIV = 1'b1;
`else
  localparam int LAT   = 5;
  localparam bit DERIV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pid_start = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic [15:0] setpoint = '0;
  logic [15:0] data_in = '0;
  logic [15:0] kp = '0;
  logic [15:0] ki = '0;
  logic [15:0] kd = '0;
  logic        busy;
  logic        done;
  logic [1:0]  ch_out;
  logic [15:0] data_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] sp;
    logic [15:0] din;
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    int          exp_out;
  } vec_t;

  vec_t vecs [11];

  pid_mc dut (
    .clk      (clk),
    .rst      (rst),
    .pid_start(pid_start),
    .ch_sel   (ch_sel),
    .setpoint (setpoint),
    .data_in  (data_in),
    .kp       (kp),
    .ki       (ki),
    .kd       (kd),
    .busy     (busy),
    .done     (done),
    .ch_out   (ch_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Launch one request, scramble the inputs afterwards, wait (bounded) for done.
  task automatic applyStimulus(input vec_t v, output int out, output int chv,
                               output int lat, output int busy_seen);
    @(negedge clk);
    ch_sel    = v.ch;
    setpoint  = v.sp;
    data_in   = v.din;
    kp        = v.kp;
    ki        = v.ki;
    kd        = v.kd;
    pid_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pid_start = 1'b0;
    setpoint  = ~v.sp;
    data_in   = v.din + 16'd777;
    kp        = 16'd1000;
    ki        = 16'd2000;
    kd        = 16'd3000;
    ch_sel    = v.ch + 2'd1;
    busy_seen = int'(busy);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    out = int'(data_out);
    chv = int'(ch_out);
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int out, chv, lat, bsy, nd;

    vecs[0]  = '{ch: 2'd0, sp: 16'd54321, din: 16'd54321, kp: 16'd256, ki: 16'd0,     kd: 16'd0,   exp_out: 0};
    vecs[1]  = '{ch: 2'd0, sp: 16'd54321, din: 16'd52000, kp: 16'd256, ki: 16'd0,     kd: 16'd0,   exp_out: 2321};
    vecs[2]  = '{ch: 2'd2, sp: 16'd1100,  din: 16'd1000,  kp: 16'd0,   ki: 16'd128,   kd: 16'd0,   exp_out: 50};
    vecs[3]  = '{ch: 2'd2, sp: 16'd1100,  din: 16'd1000,  kp: 16'd0,   ki: 16'd128,   kd: 16'd0,   exp_out: 100};
    vecs[4]  = '{ch: 2'd1, sp: 16'd1100,  din: 16'd1000,  kp: 16'd0,   ki: 16'd128,   kd: 16'd0,   exp_out: 50};
    vecs[5]  = '{ch: 2'd3, sp: 16'd1010,  din: 16'd1000,  kp: 16'd0,   ki: 16'd0,     kd: 16'd256, exp_out: DERIV ? 10 : 0};
    vecs[6]  = '{ch: 2'd3, sp: 16'd1030,  din: 16'd1000,  kp: 16'd0,   ki: 16'd0,     kd: 16'd256, exp_out: DERIV ? 20 : 0};
    vecs[7]  = '{ch: 2'd2, sp: 16'd65535, din: 16'd0,     kp: 16'd0,   ki: 16'd65535, kd: 16'd0,   exp_out: 65535};
    vecs[8]  = '{ch: 2'd2, sp: 16'd65535, din: 16'd0,     kp: 16'd0,   ki: 16'd65535, kd: 16'd0,   exp_out: 65535};
    vecs[9]  = '{ch: 2'd2, sp: 16'd65535, din: 16'd0,     kp: 16'd0,   ki: 16'd65535, kd: 16'd0,   exp_out: 65535};
    // integ[2] stayed frozen at 200: 65535*(200-100) >> 8 = 25599
    vecs[10] = '{ch: 2'd2, sp: 16'd100,   din: 16'd200,   kp: 16'd0,   ki: 16'd65535, kd: 16'd0,   exp_out: 25599};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_ch_out", int'(ch_out), 0);
    checkOutput("reset_data_out", int'(data_out), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], out, chv, lat, bsy);
      checkOutput($sformatf("vec%0d_busy", i), bsy, 1);
      checkOutput($sformatf("vec%0d_latency", i), lat, LAT);
      checkOutput($sformatf("vec%0d_data_out", i), out, vecs[i].exp_out);
      checkOutput($sformatf("vec%0d_ch_out", i), chv, int'(vecs[i].ch));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), int'(done), 0);
    end

    // Busy guard: a second start while busy must be dropped.
    @(negedge clk);
    ch_sel = 2'd0; setpoint = 16'd54321; data_in = 16'd56000;
    kp = 16'd256; ki = 16'd0; kd = 16'd0;
    pid_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pid_start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      if (lat == 3) begin
        pid_start = 1'b1;
        data_in   = 16'd0;
        ch_sel    = 2'd1;
      end else begin
        pid_start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    pid_start = 1'b0;
    checkOutput("guard_latency", lat, LAT);
    checkOutput("guard_data_out", int'(data_out), 0);
    checkOutput("guard_ch_out", int'(ch_out), 0);
    countDones(12, nd);
    checkOutput("guard_single_done", nd, 0);

    // Reset in the middle of a run on channel 1.
    @(negedge clk);
    ch_sel = 2'd1; setpoint = 16'd1500; data_in = 16'd1000;
    kp = 16'd256; ki = 16'd0; kd = 16'd0;
    pid_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pid_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_data_out", int'(data_out), 0);
    checkOutput("abort_ch_out", int'(ch_out), 0);
    countDones(12, nd);
    checkOutput("abort_no_done", nd, 0);

    // Channel 1 integrator was cleared, so this behaves as a first sample.
    applyStimulus(vecs[4], out, chv, lat, bsy);
    checkOutput("post_reset_latency", lat, LAT);
    checkOutput("post_reset_data_out", out, 50);
    checkOutput("post_reset_ch_out", chv, 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
